// File: rtl/munoc_lpi_sram_responder.sv
// LPI slave endpoint: burden-tagged request parcels are served from an internal
// byte-enabled word SRAM. Read data and write acks return through a credit-managed FIFO.
module munoc_lpi_sram_responder #(
   parameter int BW_ADDR         = 32,
   parameter int BW_DATA         = 32,
   parameter int BW_BURDEN       = 1,
   parameter int DEPTH           = 1024,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic                                              clk,
   input  logic                                              rstnn,
   input  logic                                              clear,
   input  logic                                              enable,
   output logic                                              busy,
   output logic [1:0]                                        rlqdready,
   input  logic                                              rlqvalid,
   input  logic                                              rlqhint,
   input  logic                                              rlqlast,
   input  logic                                              rlqafy,
   input  logic [BW_BURDEN+1+BW_ADDR+BW_DATA/8+BW_DATA-1:0]  rlqdata,
   input  logic [1:0]                                        rlydready,
   output logic                                              rlyvalid,
   output logic                                              rlyhint,
   output logic                                              rlylast,
   output logic [BW_BURDEN+BW_DATA-1:0]                      rlydata
);

   localparam int SW        = BW_DATA / 8;
   localparam int RQ_W      = BW_BURDEN + 1 + BW_ADDR + SW + BW_DATA;
   localparam int BYTE_BITS = $clog2(SW);
   localparam int IDX_W     = $clog2(DEPTH);
   localparam int PW        = $clog2(RESP_FIFO_DEPTH);
   localparam int CW        = PW + 1;
   localparam int EW        = BW_BURDEN + 2 + BW_DATA;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } state_t;

   logic [BW_DATA-1:0]   wdata_s;
   logic [SW-1:0]        wstrb_s;
   logic [BW_ADDR-1:0]   addr_s;
   logic                 write_s;
   logic [BW_BURDEN-1:0] burden_s;
   logic [IDX_W-1:0]     idx_s;

   logic [BW_DATA-1:0]   mem [DEPTH];
   logic [BW_DATA-1:0]   rd_data_r;
   logic [EW-1:0]        fifo_mem [RESP_FIFO_DEPTH];

   state_t               state_r, state_nx_s;
   logic [PW-1:0]        rd_ptr_r, wr_ptr_r, rd_ptr_nx_s, wr_ptr_nx_s;
   logic [CW-1:0]        cnt_r, cnt_nx_s;
   logic                 slot_valid_r, slot_hint_r, slot_last_r;
   logic [BW_BURDEN-1:0] slot_burden_r;
   logic                 out_valid_r, out_hint_r, out_last_r;
   logic [BW_BURDEN+BW_DATA-1:0] out_data_r;
   logic                 credit_r, rdy1_r, busy_r;
   logic [BW_BURDEN-1:0] burst_burden_r;
   logic                 burst_write_r;
   logic                 protocol_err;

   logic                 beat_acc_s, pop_s, push_s, slot_nx_s, err_nx_s;
   logic                 head_valid_s, credit_nx_s, busy_nx_s;
   logic [BW_DATA-1:0]   slot_data_s;
   logic [EW-1:0]        push_entry_s, head_entry_s;
   logic                 unused_s;

   assign wdata_s  = rlqdata[BW_DATA-1:0];
   assign wstrb_s  = rlqdata[BW_DATA +: SW];
   assign addr_s   = rlqdata[BW_DATA+SW +: BW_ADDR];
   assign write_s  = rlqdata[BW_DATA+SW+BW_ADDR];
   assign burden_s = rlqdata[RQ_W-1 -: BW_BURDEN];
   assign idx_s    = addr_s[BYTE_BITS +: IDX_W];
   assign unused_s = ^{rlqhint, rlydready[1], addr_s};

   assign rlqdready = {rdy1_r, credit_r & enable & ~clear};
   assign beat_acc_s = rlqvalid & rlqdready[0];
   assign rlyvalid  = out_valid_r;
   assign rlyhint   = out_hint_r;
   assign rlylast   = out_last_r;
   assign rlydata   = out_data_r;
   assign busy      = busy_r;

   // Next-state computation for FIFO pointers, registered head, credit and burst FSM
   always_comb begin
      pop_s        = out_valid_r & rlydready[0] & enable & ~clear;
      push_s       = slot_valid_r & ~clear;
      slot_data_s  = slot_hint_r ? {BW_DATA{1'b0}} : rd_data_r;
      push_entry_s = {slot_burden_r, slot_hint_r, slot_last_r, slot_data_s};
      slot_nx_s    = beat_acc_s & (~write_s | (rlqlast & rlqafy));

      if (clear) begin
         rd_ptr_nx_s = {PW{1'b0}};
         wr_ptr_nx_s = {PW{1'b0}};
         cnt_nx_s    = {CW{1'b0}};
      end else begin
         rd_ptr_nx_s = rd_ptr_r + PW'(pop_s);
         wr_ptr_nx_s = wr_ptr_r + PW'(push_s);
         cnt_nx_s    = cnt_r + CW'(push_s) - CW'(pop_s);
      end

      // a push into an (about to be) empty FIFO bypasses storage straight to the head
      if (cnt_nx_s == {CW{1'b0}}) begin
         head_valid_s = 1'b0;
         head_entry_s = {EW{1'b0}};
      end else if (cnt_r == CW'(pop_s)) begin
         head_valid_s = 1'b1;
         head_entry_s = push_entry_s;
      end else begin
         head_valid_s = 1'b1;
         head_entry_s = fifo_mem[rd_ptr_nx_s];
      end

      case (state_r)
         IDLE:    state_nx_s = (beat_acc_s & ~rlqlast) ? BURST : IDLE;
         BURST:   state_nx_s = (beat_acc_s & rlqlast) ? IDLE : BURST;
         FLUSH:   state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
      if (clear) begin
         state_nx_s = FLUSH;
      end else begin
         state_nx_s = state_nx_s;
      end

      err_nx_s    = (state_r == BURST) & beat_acc_s &
                    ((burden_s != burst_burden_r) | (write_s != burst_write_r));
      credit_nx_s = ((cnt_nx_s + CW'(slot_nx_s)) < CW'(RESP_FIFO_DEPTH)) &
                    (state_nx_s != FLUSH);
      busy_nx_s   = (cnt_nx_s != {CW{1'b0}}) | slot_nx_s | (state_nx_s == BURST);
   end

   // Burst FSM, response FIFO control, in-flight slot and registered outputs
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_r        <= IDLE;
         rd_ptr_r       <= {PW{1'b0}};
         wr_ptr_r       <= {PW{1'b0}};
         cnt_r          <= {CW{1'b0}};
         slot_valid_r   <= 1'b0;
         slot_hint_r    <= 1'b0;
         slot_last_r    <= 1'b0;
         slot_burden_r  <= {BW_BURDEN{1'b0}};
         out_valid_r    <= 1'b0;
         out_hint_r     <= 1'b0;
         out_last_r     <= 1'b0;
         out_data_r     <= {(BW_BURDEN+BW_DATA){1'b0}};
         credit_r       <= 1'b0;
         rdy1_r         <= 1'b0;
         busy_r         <= 1'b0;
         burst_burden_r <= {BW_BURDEN{1'b0}};
         burst_write_r  <= 1'b0;
         protocol_err   <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         rd_ptr_r     <= rd_ptr_nx_s;
         wr_ptr_r     <= wr_ptr_nx_s;
         cnt_r        <= cnt_nx_s;
         slot_valid_r <= slot_nx_s;
         if (beat_acc_s) begin
            slot_hint_r   <= write_s;
            slot_last_r   <= write_s | rlqlast;
            slot_burden_r <= burden_s;
         end
         if (beat_acc_s && state_r == IDLE) begin
            burst_burden_r <= burden_s;
            burst_write_r  <= write_s;
         end
         out_valid_r <= head_valid_s;
         {out_data_r[BW_BURDEN+BW_DATA-1 -: BW_BURDEN], out_hint_r, out_last_r,
          out_data_r[BW_DATA-1:0]} <= head_entry_s;
         credit_r <= credit_nx_s;
         rdy1_r   <= rlqdready[0];
         busy_r   <= busy_nx_s;
         if (clear) begin
            protocol_err <= 1'b0;
         end else if (err_nx_s) begin
            protocol_err <= 1'b1;
         end
      end
   end

   // Response FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem[wr_ptr_r] <= push_entry_s;
      end
   end

   // Word SRAM: byte-enabled write, registered read, no reset on contents
   always_ff @(posedge clk) begin
      if (beat_acc_s && write_s) begin
         for (int b = 0; b < SW; b++) begin
            if (wstrb_s[b]) begin
               mem[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
            end
         end
      end
      if (beat_acc_s && !write_s) begin
         rd_data_r <= mem[idx_s];
      end
   end

endmodule

// File: tb/tb_munoc_lpi_sram_responder.sv
// Directed bench for munoc_lpi_sram_responder: bursts, strobes, credit stall,
// address wrap, tag ordering, clear and asynchronous reset.
module tb_munoc_lpi_sram_responder;

   logic        clk = 1'b0;
   logic        rstnn, clear, enable, busy;
   logic [1:0]  rlqdready, rlydready;
   logic        rlqvalid, rlqhint, rlqlast, rlqafy;
   logic [69:0] rlqdata;
   logic        rlyvalid, rlyhint, rlylast;
   logic [32:0] rlydata;

   int          total = 0;
   int          bad = 0;
   int          k = 0;
   logic [34:0] obs_q [$];
   logic [31:0] req_addr [8];
   logic        req_bur [8];
   logic [31:0] exp_d [8];

   munoc_lpi_sram_responder dut (
      .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy),
      .rlqdready(rlqdready), .rlqvalid(rlqvalid), .rlqhint(rlqhint), .rlqlast(rlqlast),
      .rlqafy(rlqafy), .rlqdata(rlqdata), .rlydready(rlydready), .rlyvalid(rlyvalid),
      .rlyhint(rlyhint), .rlylast(rlylast), .rlydata(rlydata)
   );

   always #5 clk = ~clk;

   // records every response transfer, sampled mid-cycle
   always @(negedge clk) begin
      if (rstnn && rlyvalid && rlydready[0] && enable && !clear)
         obs_q.push_back({rlydata[32], rlyhint, rlylast, rlydata[31:0]});
   end

   function automatic logic [69:0] mk(input logic bur, input logic wr, input logic [31:0] a,
                                      input logic [3:0] s, input logic [31:0] d);
      return {bur, wr, a, s, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic bur, input logic wr, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d,
                            input logic last, input logic afy);
      logic got;
      got = 1'b0;
      rlqvalid = 1'b1; rlqdata = mk(bur, wr, a, s, d); rlqlast = last; rlqafy = afy;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk); got = rlqdready[0];
         @(posedge clk); #1;
      end
      rlqvalid = 1'b0;
      chk("beat_accept", got, 1);
   endtask

   task automatic stream_reads(input int n, input int cycles, input bit rnd);
      logic adv;
      for (int c = 0; c < cycles && k < n; c++) begin
         rlqvalid = 1'b1; rlqdata = mk(req_bur[k], 1'b0, req_addr[k], 4'h0, 32'h0);
         rlqlast = 1'b1; rlqafy = 1'b0;
         if (rnd) rlydready = {1'b0, 1'($urandom_range(0, 1))};
         @(negedge clk); adv = rlqdready[0];
         @(posedge clk); #1;
         if (adv) k++;
      end
      rlqvalid = 1'b0;
   endtask

   task automatic wait_resp(input int n, input string tag);
      for (int c = 0; c < 300 && obs_q.size() < n; c++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      chk(tag, obs_q.size(), n);
   endtask

   initial begin
      rstnn = 1'b0; clear = 1'b0; enable = 1'b1; rlydready = 2'b01;
      rlqvalid = 1'b0; rlqhint = 1'b0; rlqlast = 1'b0; rlqafy = 1'b0; rlqdata = '0;
      #25;
      chk("rst_rlqdready", rlqdready, 0);
      chk("rst_rlyvalid", rlyvalid, 0);
      chk("rst_rly_misc", {rlyhint, rlylast, rlydata}, 0);
      chk("rst_busy", busy, 0);
      rstnn = 1'b1;
      @(posedge clk); #1;

      // 1: write burst with ack, then read burst
      for (int i = 0; i < 4; i++)
         send_beat(1'b1, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), (i == 3), 1'b1);
      wait_resp(1, "t1_ack_count");
      chk("t1_ack", obs_q[0], {1'b1, 1'b1, 1'b1, 32'h0});
      obs_q.delete();
      for (int i = 0; i < 4; i++)
         send_beat(1'b1, 1'b0, 32'h100 + 32'(4*i), 4'h0, 32'h0, (i == 3), 1'b0);
      wait_resp(4, "t1_rd_count");
      for (int i = 0; i < 4; i++)
         chk("t1_rd", obs_q[i], {1'b1, 1'b0, (i == 3), 32'hA0 + 32'(i)});
      obs_q.delete();

      // 2: partial strobe merge, writes without afy give no response
      send_beat(1'b0, 1'b1, 32'h200, 4'hF, 32'h1122_3344, 1'b1, 1'b0);
      send_beat(1'b0, 1'b1, 32'h200, 4'h2, 32'h0000_5500, 1'b1, 1'b0);
      send_beat(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, 1'b1, 1'b0);
      wait_resp(1, "t2_count");
      chk("t2_merge", obs_q[0], {1'b0, 1'b0, 1'b1, 32'h1122_5544});
      obs_q.delete();

      // 4: index wraps modulo DEPTH
      send_beat(1'b0, 1'b1, 32'(1024*4 + 8), 4'hF, 32'h0000_DEAD, 1'b1, 1'b0);
      send_beat(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 1'b0);
      wait_resp(1, "t4_count");
      chk("t4_wrap", obs_q[0], {1'b0, 1'b0, 1'b1, 32'h0000_DEAD});
      obs_q.delete();

      // 3: credit stall with the sink blocked
      req_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h10C, 32'h108, 32'h104};
      exp_d    = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h1122_5544, 32'hA3, 32'hA2, 32'hA1};
      req_bur  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      rlydready = 2'b00;
      k = 0;
      stream_reads(8, 20, 1'b0);
      chk("t3_stall_accepted", k, 4);
      chk("t3_stall_ready", rlqdready[0], 0);
      chk("t3_stall_valid", rlyvalid, 1);
      rlydready = 2'b01;
      stream_reads(8, 100, 1'b0);
      chk("t3_all_accepted", k, 8);
      wait_resp(8, "t3_count");
      for (int i = 0; i < 8; i++)
         chk("t3_order", obs_q[i], {1'b0, 1'b0, 1'b1, exp_d[i]});
      obs_q.delete();

      // 5: alternating tags with a random sink
      for (int i = 0; i < 8; i++) begin
         req_addr[i] = 32'h100 + 32'(4*(i % 4));
         exp_d[i]    = 32'hA0 + 32'(i % 4);
         req_bur[i]  = 1'(i % 2);
      end
      k = 0;
      stream_reads(8, 300, 1'b1);
      rlydready = 2'b01;
      chk("t5_all_accepted", k, 8);
      wait_resp(8, "t5_count");
      for (int i = 0; i < 8; i++)
         chk("t5_tag_order", obs_q[i], {req_bur[i], 1'b0, 1'b1, exp_d[i]});
      obs_q.delete();

      // burst whose second beat changes burden flags a protocol error
      send_beat(1'b0, 1'b1, 32'h300, 4'hF, 32'h1, 1'b0, 1'b0);
      send_beat(1'b1, 1'b1, 32'h304, 4'hF, 32'h2, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("perr_set", dut.protocol_err, 1);

      // 6: clear drops queued responses but keeps SRAM
      rlydready = 2'b00;
      for (int i = 0; i < 3; i++)
         send_beat(1'b0, 1'b0, 32'h104, 4'h0, 32'h0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_queued_valid", rlyvalid, 1);
      chk("t6_queued_busy", busy, 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("t6_clear_valid", rlyvalid, 0);
      chk("t6_clear_busy", busy, 0);
      chk("perr_cleared", dut.protocol_err, 0);
      rlydready = 2'b01;
      send_beat(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b0);
      wait_resp(1, "t6_post_count");
      chk("t6_sram_kept", obs_q[0], {1'b1, 1'b0, 1'b1, 32'hA0});
      obs_q.delete();

      // asynchronous reset in the middle of a read burst
      rlydready = 2'b00;
      send_beat(1'b1, 1'b0, 32'h104, 4'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      chk("t6_pre_rst_valid", rlyvalid, 1);
      rstnn = 1'b0;
      #1;
      chk("t6_rst_outputs", {rlqdready, rlyvalid, rlyhint, rlylast, rlydata, busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
